branch_resolve_unit: RTL and testbench

//  Execute-stage branch/jump resolver; successor to the combinational branch comparator.

---
 rtl/bru_pkg.sv | 36 +++
 rtl/branch_cmp.sv | 46 ++++
 rtl/branch_resolve_unit.sv | 199 +++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// ---------------------------------------------------------------------------
// bru_pkg
// Shared types and constants for the branch resolve unit.
//   bru_kind_e : op class presented to the resolver (BR, JAL, JALR, illegal)
//   F3_*       : branch condition encodings carried on func_3
//   bru_res_t  : flag bundle held in the output slot
//   f3_is_legal: func_3 values 010/011 have no branch meaning
// ---------------------------------------------------------------------------
package bru_pkg;

  typedef enum logic [1:0] {
    BRU_BR   = 2'd0,
    BRU_JAL  = 2'd1,
    BRU_JALR = 2'd2,
    BRU_ILL  = 2'd3
  } bru_kind_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic taken;
    logic mispredict;
    logic illegal;
    logic misalign;
  } bru_res_t;

  function automatic logic f3_is_legal(input logic [2:0] f3);
    return f3[2] | ~f3[1];
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// ---------------------------------------------------------------------------
// branch_cmp
// Combinational branch condition evaluator.
// Ports:
//   i_func_3  in  3     branch condition encoding
//   i_rs1     in  XLEN  first operand
//   i_rs2     in  XLEN  second operand
//   o_taken   out 1     condition holds (0 for illegal encodings)
//   o_illegal out 1     func_3 is 010 or 011
// ---------------------------------------------------------------------------
module branch_cmp
  import bru_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_func_3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_taken,
  output logic            o_illegal
);

  logic w_eq;
  logic w_lt;
  logic w_ltu;

  assign w_eq  = (i_rs1 == i_rs2);
  assign w_lt  = ($signed(i_rs1) < $signed(i_rs2));
  assign w_ltu = (i_rs1 < i_rs2);

  assign o_illegal = ~f3_is_legal(i_func_3);

  always_comb begin
    o_taken = 1'b0;
    case (i_func_3)
      F3_BEQ:  o_taken = w_eq;
      F3_BNE:  o_taken = ~w_eq;
      F3_BLT:  o_taken = w_lt;
      F3_BGE:  o_taken = ~w_lt;
      F3_BLTU: o_taken = w_ltu;
      F3_BGEU: o_taken = ~w_ltu;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
// Execute-stage resolver for B-type, JAL and JALR ops. Computes direction,
// next PC and link address, compares against the fetch prediction and holds
// the result in a single registered slot toward writeback/commit. A fetch
// redirect strobe fires once per mispredicted op, on the cycle it is consumed.
//
// Optional feature macro: BRU_PERF_CNT_EN adds saturating performance
// counters perf_br_cnt / perf_mispred_cnt (width CNT_W).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready = !out_valid | out_ready; an op is accepted when
// in_valid & in_ready & !flush_i. out_* stay stable while out_valid & !out_ready.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush_i             kills the held op and any op presented this cycle
//   in_valid/in_ready   input handshake
//   in_kind, in_func_3  op class and branch condition
//   in_pc, in_rs1, in_rs2, in_imm          op operands
//   in_pred_taken, in_pred_target          fetch prediction
//   out_valid/out_ready output handshake
//   out_taken, out_target, out_link        resolved direction, next PC, pc+4
//   out_mispredict, out_illegal, out_misalign  status flags
//   redirect_valid, redirect_pc            fetch redirect
//   perf_br_cnt, perf_mispred_cnt          (BRU_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN = 32
`ifdef BRU_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_kind,
  input  logic [2:0]      in_func_3,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_pred_taken,
  input  logic [XLEN-1:0] in_pred_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_link,
  output logic            out_mispredict,
  output logic            out_illegal,
  output logic            out_misalign,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_br_cnt,
  output logic [CNT_W-1:0] perf_mispred_cnt
`endif
);

  // JALR clears bit 0 of the computed address.
  localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  bru_kind_e       w_kind;
  logic            w_cmp_taken;
  logic            w_cmp_illegal;
  logic [XLEN-1:0] w_link;
  logic [XLEN-1:0] w_pc_rel_tgt;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_jump_tgt;
  logic [XLEN-1:0] w_target;
  logic            w_taken;
  logic            w_illegal;
  logic            w_misalign;
  logic            w_mispredict;
  logic            w_accept;
  logic            w_consume;
  bru_res_t        w_res;

  logic            r_valid;
  bru_res_t        r_res;
  logic [XLEN-1:0] r_target;
  logic [XLEN-1:0] r_link;

  assign w_kind = bru_kind_e'(in_kind);

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .i_func_3  (in_func_3),
    .i_rs1     (in_rs1),
    .i_rs2     (in_rs2),
    .o_taken   (w_cmp_taken),
    .o_illegal (w_cmp_illegal)
  );

  // All sums wrap modulo 2^XLEN.
  assign w_link       = in_pc + XLEN'(4);
  assign w_pc_rel_tgt = in_pc + in_imm;
  assign w_jalr_sum   = in_rs1 + in_imm;

  // func_3 is only a condition for BR; JAL/JALR ignore it.
  always_comb begin
    w_taken    = 1'b0;
    w_illegal  = 1'b0;
    w_jump_tgt = w_pc_rel_tgt;
    case (w_kind)
      BRU_BR: begin
        w_taken   = w_cmp_taken & ~w_cmp_illegal;
        w_illegal = w_cmp_illegal;
      end
      BRU_JAL: begin
        w_taken = 1'b1;
      end
      BRU_JALR: begin
        w_taken    = 1'b1;
        w_jump_tgt = w_jalr_sum & JALR_MASK;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // Illegal ops resolve as not-taken fall-through, so the generic mispredict
  // expression already yields pred_taken for them.
  assign w_target   = w_taken ? w_jump_tgt : w_link;
  assign w_misalign = w_taken & w_target[1];
  // A misaligned target traps downstream; fetch must not be redirected to it.
  assign w_mispredict = ~w_misalign &
                        ((w_taken != in_pred_taken) |
                         (w_taken & in_pred_taken & (w_target != in_pred_target)));

  assign w_res = '{taken:      w_taken,
                   mispredict: w_mispredict,
                   illegal:    w_illegal,
                   misalign:   w_misalign};

  assign in_ready  = ~r_valid | out_ready;
  assign w_accept  = in_valid & in_ready & ~flush_i;
  assign w_consume = r_valid & out_ready & ~flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_res    <= '0;
      r_target <= '0;
      r_link   <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_res    <= w_res;
      r_target <= w_target;
      r_link   <= w_link;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid      = r_valid;
  assign out_taken      = r_res.taken;
  assign out_target     = r_target;
  assign out_link       = r_link;
  assign out_mispredict = r_res.mispredict;
  assign out_illegal    = r_res.illegal;
  assign out_misalign   = r_res.misalign;

  // Strobe only on the consume cycle, so each op redirects at most once.
  assign redirect_valid = w_consume & r_res.mispredict;
  assign redirect_pc    = r_target;

`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  // Saturating; flush does not clear history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_cnt      <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_consume && (r_br_cnt != '1)) begin
        r_br_cnt <= r_br_cnt + CNT_W'(1);
      end
      if (w_consume && r_res.mispredict && (r_mispred_cnt != '1)) begin
        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
      end
    end
  end

  assign perf_br_cnt      = r_br_cnt;
  assign perf_mispred_cnt = r_mispred_cnt;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
// Directed and randomized checks of branch_resolve_unit (default build).
// Expected results come from a reference model of the resolution rules and a
// queue holding what the output slot should contain.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam int XLEN = 32;
  // Expected record: {taken, target, link, mispredict, illegal, misalign}
  localparam int RW = 1 + XLEN + XLEN + 3;

  logic            clk;
  logic            rst_n;
  logic            flush_i;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_kind;
  logic [2:0]      in_func_3;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_imm;
  logic            in_pred_taken;
  logic [XLEN-1:0] in_pred_target;
  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [XLEN-1:0] out_target;
  logic [XLEN-1:0] out_link;
  logic            out_mispredict;
  logic            out_illegal;
  logic            out_misalign;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [RW-1:0] exp_q[$];

  branch_resolve_unit #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush_i),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_kind        (in_kind),
    .in_func_3      (in_func_3),
    .in_pc          (in_pc),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_imm         (in_imm),
    .in_pred_taken  (in_pred_taken),
    .in_pred_target (in_pred_target),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_taken      (out_taken),
    .out_target     (out_target),
    .out_link       (out_link),
    .out_mispredict (out_mispredict),
    .out_illegal    (out_illegal),
    .out_misalign   (out_misalign),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [RW-1:0] model(
    input logic [1:0] k, input logic [2:0] f3,
    input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
    input logic [31:0] imm, input logic pt, input logic [31:0] ptgt);
    logic        taken, ill, mis, mp;
    logic [31:0] tgt, link, nxt;
    link  = pc + 32'd4;
    tgt   = pc + imm;
    taken = 1'b0;
    ill   = 1'b0;
    case (k)
      2'd0: begin
        case (f3)
          3'd0: taken = (rs1 == rs2);
          3'd1: taken = (rs1 != rs2);
          3'd4: taken = ($signed(rs1) <  $signed(rs2));
          3'd5: taken = ($signed(rs1) >= $signed(rs2));
          3'd6: taken = (rs1 <  rs2);
          3'd7: taken = (rs1 >= rs2);
          default: ill = 1'b1;
        endcase
      end
      2'd1: taken = 1'b1;
      2'd2: begin
        taken = 1'b1;
        tgt   = (rs1 + imm) & 32'hFFFF_FFFE;
      end
      default: ill = 1'b1;
    endcase
    nxt = taken ? tgt : link;
    mis = taken && nxt[1];
    mp  = !mis && ((taken != pt) || (taken && pt && (nxt != ptgt)));
    return {taken, nxt, link, mp, ill, mis};
  endfunction

  // ---------------- scoreboard: what the slot should hold ----------------
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (flush_i) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && exp_q.size() == 0)
        exp_q.push_back(model(in_kind, in_func_3, in_pc, in_rs1, in_rs2,
                              in_imm, in_pred_taken, in_pred_target));
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [RW-1:0] e;
    logic          v;
    logic          exp_redir;
    v = (exp_q.size() != 0);
    check("out_valid", 32'(out_valid), 32'(v));
    check("in_ready", 32'(in_ready), 32'(!v || out_ready));
    if (v) begin
      e = exp_q[0];
      check("out_taken",      32'(out_taken),      32'(e[RW-1]));
      check("out_target",     out_target,          e[RW-2 -: 32]);
      check("out_link",       out_link,            e[34:3]);
      check("out_mispredict", 32'(out_mispredict), 32'(e[2]));
      check("out_illegal",    32'(out_illegal),    32'(e[1]));
      check("out_misalign",   32'(out_misalign),   32'(e[0]));
      exp_redir = e[2] && out_ready && !flush_i;
      check("redirect_valid", 32'(redirect_valid), 32'(exp_redir));
      if (exp_redir) check("redirect_pc", redirect_pc, e[RW-2 -: 32]);
    end else begin
      check("redirect_idle", 32'(redirect_valid), 32'd0);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [1:0] k, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm,
                       input logic pt, input logic [31:0] ptgt);
    in_valid       = 1'b1;
    in_kind        = k;
    in_func_3      = f3;
    in_pc          = pc;
    in_rs1         = rs1;
    in_rs2         = rs2;
    in_imm         = imm;
    in_pred_taken  = pt;
    in_pred_target = ptgt;
  endtask

  task automatic drive_random();
    logic [11:0] s;
    logic [31:0] pc, rs1, rs2, imm;
    s   = 12'($urandom);
    pc  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                      : ($urandom & 32'hFFFF_FFFC);
    rs1 = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 8)) - 32'd4;
    rs2 = ($urandom_range(0, 2) == 0) ? rs1 : (($urandom_range(0, 1) == 0) ? $urandom
                                                : 32'($urandom_range(0, 8)) - 32'd4);
    imm = ($urandom_range(0, 3) == 0) ? $urandom : {{20{s[11]}}, s};
    drive(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), pc, rs1, rs2, imm,
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 1) == 0) ? (pc + imm) : $urandom);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n          = 1'b0;
    flush_i        = 1'b0;
    out_ready      = 1'b1;
    in_valid       = 1'b0;
    in_kind        = 2'd0;
    in_func_3      = 3'd0;
    in_pc          = '0;
    in_rs1         = '0;
    in_rs2         = '0;
    in_imm         = '0;
    in_pred_taken  = 1'b0;
    in_pred_target = '0;

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_redirect", 32'(redirect_valid), 32'd0);
    check("rst_target", out_target, 32'd0);
    check("rst_link", out_link, 32'd0);
    check("rst_flags", {28'd0, out_taken, out_mispredict, out_illegal, out_misalign}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // BLT signed: -1 < 1 taken, predicted not taken -> redirect
    drive(2'd0, 3'b100, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 32'h0);
    tick();
    check("blt_taken", 32'(out_taken), 32'd1);
    check("blt_target", out_target, 32'h120);
    check("blt_redirect", 32'(redirect_valid), 32'd1);
    check("blt_redirect_pc", redirect_pc, 32'h120);

    // BLTU unsigned: 0xFFFFFFFF < 1 is false
    drive(2'd0, 3'b110, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 32'h0);
    tick();
    check("bltu_taken", 32'(out_taken), 32'd0);
    check("bltu_target", out_target, 32'h104);
    check("bltu_redirect", 32'(redirect_valid), 32'd0);

    // JALR bit0 cleared
    drive(2'd2, 3'b000, 32'h300, 32'h203, 32'h0, 32'h0, 1'b1, 32'h202);
    tick();
    check("jalr_target", out_target, 32'h202);
    check("jalr_link", out_link, 32'h304);
    check("jalr_mispredict", 32'(out_mispredict), 32'd0);

    // JALR misaligned target: no redirect
    drive(2'd2, 3'b000, 32'h300, 32'h206, 32'h0, 32'h0, 1'b1, 32'h0);
    tick();
    check("jalr_misalign", 32'(out_misalign), 32'd1);
    check("jalr_mis_redirect", 32'(redirect_valid), 32'd0);

    // JAL wrapping
    drive(2'd1, 3'b000, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'd8, 1'b0, 32'h0);
    tick();
    check("jal_wrap_target", out_target, 32'h4);
    check("jal_wrap_link", out_link, 32'h0);

    // Illegal func_3 on a branch
    drive(2'd0, 3'b010, 32'h400, 32'h5, 32'h5, 32'h40, 1'b1, 32'h440);
    tick();
    check("ill_f3_illegal", 32'(out_illegal), 32'd1);
    check("ill_f3_taken", 32'(out_taken), 32'd0);
    check("ill_f3_target", out_target, 32'h404);

    // Illegal kind
    drive(2'd3, 3'b000, 32'h500, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    check("ill_kind", 32'(out_illegal), 32'd1);
    idle();
    tick();

    // Backpressure: op held 3 cycles, single redirect on release
    out_ready = 1'b0;
    drive(2'd0, 3'b000, 32'h600, 32'h7, 32'h7, 32'h40, 1'b0, 32'h0);
    tick();
    drive(2'd1, 3'b000, 32'h700, 32'h0, 32'h0, 32'h10, 1'b1, 32'h710);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_target", out_target, 32'h640);
      check("stall_redirect", 32'(redirect_valid), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check_outputs();
    check("release_redirect", 32'(redirect_valid), 32'd1);
    tick();
    check("after_release_target", out_target, 32'h710);
    idle();
    tick();

    // Flush with a held op and a new op presented
    drive(2'd0, 3'b001, 32'h800, 32'h1, 32'h2, 32'h80, 1'b0, 32'h0);
    tick();
    drive(2'd1, 3'b000, 32'h900, 32'h0, 32'h0, 32'h4, 1'b0, 32'h0);
    flush_i = 1'b1;
    #1;
    check_outputs();
    check("flush_redirect", 32'(redirect_valid), 32'd0);
    tick();
    flush_i = 1'b0;
    idle();
    check("flush_out_valid", 32'(out_valid), 32'd0);
    tick();
    check("flush_dropped", 32'(out_valid), 32'd0);

    // Asynchronous reset while an op is held
    out_ready = 1'b0;
    drive(2'd1, 3'b000, 32'hA00, 32'h0, 32'h0, 32'h20, 1'b0, 32'h0);
    tick();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_redirect", 32'(redirect_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) drive_random();
      else idle();
      out_ready = ($urandom_range(0, 9) < 7);
      flush_i   = ($urandom_range(0, 29) == 0);
      tick();
    end
    flush_i = 1'b0;
    idle();
    out_ready = 1'b1;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
